conv_mul_arb: RTL and testbench
===============================

CONV_MUL_ARB -- requirements
Module: conv_mul_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the multiplier; legal values 2..8.
REQ-002 Parameter A_W, default 16: signed width of operand a.
REQ-003 Parameter B_W, default 8: signed width of operand b.
REQ-004 Parameter P_W, default 24: signed product width, equal to A_W+B_W.
REQ-005 Port ap_clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 Port ap_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 Port req_valid, input, N_REQ bits: bit i high means requester i offers an operand pair.
REQ-008 Port req_ready, output, N_REQ bits: bit i high means requester i's pair is accepted this cycle; at most one bit set.
REQ-009 Port req_a, input, N_REQ*A_W bits: requester i operand a, bits [i*A_W +: A_W], signed.
REQ-010 Port req_b, input, N_REQ*B_W bits: requester i operand b, bits [i*B_W +: B_W], signed.
REQ-011 Port out_valid, output, 1 bit: out_p/out_id hold a valid result.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the result when out_valid and out_ready are both high.
REQ-013 Port out_p, output, P_W bits: signed product a*b.
REQ-014 Port out_id, output, clog2(N_REQ) bits: index of the requester that issued the product.

Function
REQ-015 The block SHALL contain two pipeline stages: S1 registers the granted operands and id; S2 registers the product and id.
REQ-016 Pipeline advance SHALL be adv = !s2_valid || out_ready; when adv is low, S1 and S2 hold their contents and valid flags.
REQ-017 A grant SHALL occur only in cycles where adv is high and at least one req_valid bit is set.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and scans ascending indices modulo N_REQ.
REQ-019 req_ready[i] SHALL be high only for the single granted index; it is combinational from req_valid, rr_ptr and adv.
REQ-020 After a grant to index g, rr_ptr SHALL become (g+1) mod N_REQ; with no grant, rr_ptr SHALL be unchanged.
REQ-021 Latency SHALL be 2 cycles: a pair accepted at edge k appears on out_p at edge k+2 when no stall occurs.
REQ-022 Sustained throughput SHALL be one product per cycle while out_ready stays high.
REQ-023 The product SHALL be the full-precision signed product sign-extended to P_W; no truncation or saturation.
REQ-024 Results SHALL leave in grant order; out_id SHALL equal the granted index carried through S1 and S2.
REQ-025 When adv is high and no grant occurs, S1 valid SHALL clear and the S1 bubble SHALL propagate to S2 on the next advance.
REQ-026 out_valid, out_p and out_id SHALL be register outputs, stable while out_valid is high and out_ready is low.
REQ-027 A requester dropping req_valid without a grant SHALL have no effect; no request is latched outside a grant.

Reset
REQ-028 While ap_rst is high at a clock edge, S1/S2 valid flags SHALL clear, rr_ptr SHALL become 0, and out_p and out_id SHALL become 0.
REQ-029 During the reset cycle req_ready SHALL be all zero.
REQ-030 Reset mid-stream SHALL discard all in-flight products; none of them appear after reset.

Structure
REQ-031 A shared package conv_pkg SHALL hold the A_W/B_W/P_W defaults and the id-width function.
REQ-032 The round-robin grant logic SHALL be the sub-module conv_rr_arb (inputs req, ptr, en; outputs one-hot grant and index).
REQ-033 The multiply SHALL be a single signed A_W x B_W operator between S1 and S2, shared by all requesters.

Verification
REQ-034 Reset, then req 0 only, a=3, b=-2 -> req_ready[0] high one cycle; out_valid two cycles later with out_p=-6 and out_id=0.
REQ-035 All four requesters valid continuously with out_ready=1 -> grants 0,1,2,3,0,... one per cycle; out_id sequence matches.
REQ-036 Extremes: a=-32768, b=-128 -> out_p=4194304; a=32767, b=-128 -> out_p=-4194176.
REQ-037 out_ready low for 5 cycles with the pipe full -> req_ready all zero and out_p/out_id stable; after release, no loss or duplication.
REQ-038 Assert ap_rst with both stages valid -> out_valid low next cycle, rr_ptr=0, and the first post-reset grant goes to the lowest valid index.
REQ-039 Only req 2 valid after a grant to req 3 -> req 2 granted (wrap-around); rr_ptr then 3.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and helpers for the conv_mul_arb block.
//   A_W_DEF / B_W_DEF / P_W_DEF : default operand widths and the
//                                 full-precision product width.
//   id_width(n)                 : bits needed to carry a requester
//                                 index for n requesters (minimum 1).
package conv_pkg;

    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 8;
    localparam int P_W_DEF = A_W_DEF + B_W_DEF;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_rr_arb.sv
// conv_rr_arb: combinational round-robin arbiter.
//   req   [N-1:0]  : request vector
//   ptr   [IW-1:0] : index where the search starts (highest priority)
//   en             : grant enable; no grant is produced while low
//   grant [N-1:0]  : one-hot grant (all zero when nothing is granted)
//   idx   [IW-1:0] : index of the granted requester (0 when no grant)
// The search visits ptr, ptr+1, ... wrapping modulo N, and the first
// requester found with its req bit set wins.
module conv_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // One extra bit so ptr + k cannot overflow before the modulo fold.
    localparam int SW = IW + 1;

    logic [SW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + SW'(k);
            // ptr < N and k < N, so one subtraction is enough to wrap.
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (en && !found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                grant[cand[IW-1:0]] = 1'b1;
                idx                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/conv_mul_arb.sv
// conv_mul_arb: N_REQ requesters share one signed A_W x B_W multiplier.
//   ap_clk, ap_rst         : clock, synchronous active-high reset
//   req_valid [N_REQ-1:0]  : requester i offers an operand pair
//   req_ready [N_REQ-1:0]  : requester i's pair is taken this cycle (one-hot or zero)
//   req_a [N_REQ*A_W-1:0]  : operand a of requester i at [i*A_W +: A_W], signed
//   req_b [N_REQ*B_W-1:0]  : operand b of requester i at [i*B_W +: B_W], signed
//   out_valid/out_ready    : result handshake
//   out_p [P_W-1:0]        : signed product a*b, full precision
//   out_id [ID_W-1:0]      : requester that issued the product
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. req_ready is combinational and may depend on
// req_valid; out_valid/out_p/out_id are registers and hold steady while
// out_valid is high and out_ready is low.
//
// Pipeline: the round-robin winner's operands are captured in S1, the
// product is captured in S2 (which drives the outputs). Both stages move
// together when adv = !s2_valid || out_ready, so results leave in grant
// order with two cycles of latency and one result per cycle at full rate.
// P_W is expected to equal A_W + B_W.
module conv_mul_arb
    import conv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int P_W   = A_W + B_W,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [P_W-1:0]         out_p,
    output logic [ID_W-1:0]        out_id
);

    logic                   adv;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        grant_idx;
    logic                   grant_any;
    logic [ID_W-1:0]        rr_ptr;

    logic [A_W-1:0]         sel_a;
    logic [B_W-1:0]         sel_b;

    logic                   s1_valid;
    logic signed [A_W-1:0]  s1_a;
    logic signed [B_W-1:0]  s1_b;
    logic [ID_W-1:0]        s1_id;

    logic                   s2_valid;
    logic signed [P_W-1:0]  prod;

    assign adv = !s2_valid || out_ready;

    // Arbiter disabled during reset so req_ready stays low in that cycle.
    conv_rr_arb #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (adv && !ap_rst),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    // One-hot operand select for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*A_W +: A_W];
                sel_b = req_b[i*B_W +: B_W];
            end
        end
    end

    // Both operands are sign-extended to P_W before multiplying, giving
    // the exact product without truncation.
    assign prod = P_W'(s1_a) * P_W'(s1_b);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // S1: granted operands. With adv high and no grant, a bubble enters.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (adv) begin
            s1_valid <= grant_any;
            if (grant_any) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= grant_idx;
            end
        end
    end

    // S2: product and id, driving the outputs directly.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_valid <= 1'b0;
            out_p    <= '0;
            out_id   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_p  <= prod;
                out_id <= s1_id;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_conv_mul_arb.sv
// tb_conv_mul_arb: directed bench for conv_mul_arb with default parameters.
module tb_conv_mul_arb;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int BW  = 8;
    localparam int PW  = 24;
    localparam int IDW = 2;

    // ---------------- clock / reset ----------------
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a = '0;
    logic [N*BW-1:0] req_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [PW-1:0]   out_p;
    logic [IDW-1:0]  out_id;

    conv_mul_arb dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_id    (out_id)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] prod_tab [N];          // hand-computed product per requester
    logic [IDW+PW-1:0] exp_q [$];         // {id, product} in grant order

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the output register against the queue head; pop on transfer.
    task automatic check_out(input string tag);
        logic [IDW+PW-1:0] head;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk(32'(out_valid), 32'd0, {tag, "_unexpected_out"});
            end else begin
                head = exp_q[0];
                chk(32'(out_p),  32'(head[PW-1:0]),       {tag, "_out_p"});
                chk(32'(out_id), 32'(head[IDW+PW-1:PW]),  {tag, "_out_id"});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic set_ops(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [PW-1:0] p);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
        prod_tab[i] = p;
    endtask

    // One cycle: drive inputs, check req_ready and the output, then clock.
    task automatic step(input logic [N-1:0] v, input logic ordy,
                        input logic [N-1:0] exp_rdy, input string tag);
        req_valid = v;
        out_ready = ordy;
        #1;
        chk(32'(req_ready), 32'(exp_rdy), {tag, "_ready"});
        check_out(tag);
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) exp_q.push_back({IDW'(i), prod_tab[i]});
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge ap_clk);
        // Reset with all requesters asserting: nothing may be granted.
        ap_rst    = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        chk(32'(req_ready), 32'd0, "rst_ready");
        chk(32'(out_valid), 32'd0, "rst_out_valid");
        chk(32'(out_p),     32'd0, "rst_out_p");
        chk(32'(out_id),    32'd0, "rst_out_id");
        ap_rst    = 1'b0;
        req_valid = '0;
        tick();

        // Single request 0: 3 * -2 = -6, two cycles of latency.
        set_ops(0, 16'sd3, -8'sd2, -24'sd6);
        step(4'b0001, 1'b1, 4'b0001, "single_grant");
        chk(32'(out_valid), 32'd0, "single_lat1");
        step(4'b0000, 1'b1, 4'b0000, "single_idle1");
        chk(32'(out_valid), 32'd1, "single_lat2");
        step(4'b0000, 1'b1, 4'b0000, "single_out");
        chk(32'(out_valid), 32'd0, "single_done");

        // Extremes on requesters 1 and 2 (pointer now 1).
        set_ops(1, -16'sd32768, -8'sd128, 24'sd4194304);
        set_ops(2,  16'sd32767, -8'sd128, -24'sd4194176);
        step(4'b0010, 1'b1, 4'b0010, "ext_g1");
        step(4'b0100, 1'b1, 4'b0100, "ext_g2");
        step(4'b0000, 1'b1, 4'b0000, "ext_d0");
        step(4'b0000, 1'b1, 4'b0000, "ext_d1");
        step(4'b0000, 1'b1, 4'b0000, "ext_d2");

        // Wrap-around: grant 3, then only 2 (pointer 0 -> scan 0,1,2),
        // then 0 and 3 together must go to 3 since the pointer is 3.
        set_ops(3, -16'sd32768, 8'sd127, -24'sd4161536);
        step(4'b1000, 1'b1, 4'b1000, "wrap_g3");
        step(4'b0100, 1'b1, 4'b0100, "wrap_g2");
        step(4'b1001, 1'b1, 4'b1000, "wrap_ptr3");
        step(4'b0000, 1'b1, 4'b0000, "wrap_d0");
        step(4'b0000, 1'b1, 4'b0000, "wrap_d1");
        step(4'b0000, 1'b1, 4'b0000, "wrap_d2");
        chk(32'(exp_q.size()), 32'd0, "wrap_drained");

        // Full-rate stream from pointer 0, then a 5-cycle stall.
        set_ops(0,  16'sd100,  8'sd5,   24'sd500);
        set_ops(1, -16'sd7,    8'sd9,  -24'sd63);
        set_ops(2,  16'sd1234, -8'sd3, -24'sd3702);
        step(4'b1111, 1'b1, 4'b0001, "strm0");
        step(4'b1111, 1'b1, 4'b0010, "strm1");
        step(4'b1111, 1'b1, 4'b0100, "strm2");
        step(4'b1111, 1'b1, 4'b1000, "strm3");
        step(4'b1111, 1'b1, 4'b0001, "strm4");
        step(4'b1111, 1'b1, 4'b0010, "strm5");
        step(4'b1111, 1'b1, 4'b0100, "strm6");
        step(4'b1111, 1'b1, 4'b1000, "strm7");
        for (int s = 0; s < 5; s++) begin
            step(4'b1111, 1'b0, 4'b0000, "stall");
        end
        for (int s = 0; s < 4; s++) begin
            step(4'b0000, 1'b1, 4'b0000, "drain");
        end
        chk(32'(exp_q.size()), 32'd0, "strm_drained");
        chk(32'(out_valid),    32'd0, "strm_idle");

        // Reset with both stages full; pointer would be 2 without reset.
        step(4'b1111, 1'b1, 4'b0001, "mid_g0");
        step(4'b1111, 1'b1, 4'b0010, "mid_g1");
        ap_rst    = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk(32'(req_ready), 32'd0, "mid_rst_ready");
        tick();
        ap_rst    = 1'b0;
        req_valid = '0;
        #1;
        chk(32'(out_valid), 32'd0, "mid_rst_out_valid");
        chk(32'(out_p),     32'd0, "mid_rst_out_p");
        chk(32'(out_id),    32'd0, "mid_rst_out_id");
        exp_q.delete();
        step(4'b1010, 1'b1, 4'b0010, "post_rst_first");
        step(4'b0000, 1'b1, 4'b0000, "post_d0");
        step(4'b0000, 1'b1, 4'b0000, "post_d1");
        step(4'b0000, 1'b1, 4'b0000, "post_d2");
        step(4'b0000, 1'b1, 4'b0000, "post_d3");
        chk(32'(exp_q.size()), 32'd0, "post_drained");

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
